// File: rtl/pfb_snapshot_writer.sv
// Fabric-side capture engine for the PFB snapshot BRAM.
// Software arms a capture with a rising edge on arm. The engine then writes a burst of
// din_valid-qualified words into port A, either straight away or from the next sync pulse.
// busy, done and words_written report progress back to software.
module pfb_snapshot_writer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              use_sync,
    input  logic              sync_in,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [ADDR_W:0]   capture_len,
    output logic              bram_we,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] One   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWaitSync, StCapture, StDone} state_e;

    state_e              state_q, state_d;
    logic                arm_q;
    logic                arm_re;
    logic [ADDR_W:0]     eff_len_q, eff_len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     len_clamped;
    logic                accept;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;

    assign arm_re      = arm & ~arm_q;
    assign len_clamped = ((capture_len == '0) || (capture_len > Depth)) ? Depth : capture_len;

    // State register plus arm history, latched length and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            arm_q     <= 1'b1;  // arm held high through reset must not fire
            eff_len_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm;
            eff_len_q <= eff_len_d;
            count_q   <= count_d;
        end
    end

    // Next-state, sample acceptance and counter update.
    always_comb begin
        state_d   = state_q;
        eff_len_d = eff_len_q;
        count_d   = count_q;
        accept    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (arm_re) begin
                    state_d   = use_sync ? StWaitSync : StCapture;
                    eff_len_d = len_clamped;
                    count_d   = '0;
                end
            end
            StWaitSync: begin
                // The sync sample itself is the first word captured.
                if (din_valid && sync_in) begin
                    accept  = 1'b1;
                    count_d = count_q + One;
                    state_d = (count_d == eff_len_q) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (din_valid) begin
                    accept  = 1'b1;
                    count_d = count_q + One;
                    if (count_d == eff_len_q) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status decode; busy/done move in the same cycle as the final port-A write.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StWaitSync, StCapture: busy = 1'b1;
            StDone:                done = 1'b1;
            default: ;
        endcase
    end

    // Registered port-A write: one-cycle pulse per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q <= count_q[ADDR_W-1:0];
                data_q <= din;
            end
        end
    end

    assign bram_we       = we_q;
    assign bram_en_a     = we_q;
    assign bram_addr     = addr_q;
    assign bram_wr_data  = data_q;
    assign words_written = count_q;

endmodule

// File: doc/pfb_snapshot_writer.md
Name: pfb_snapshot_writer

Overview:
- Fabric-side writer for a dual-port snapshot BRAM: captures a burst of 64-bit PFB output words into port A (`bram_we`, `bram_en_a`, `bram_addr`, `bram_wr_data`).
- Software reads the captured words back over the 32-bit CPU port.
- Capture is armed by a software register bit and optionally aligned to the PFB sync pulse.
- Reports busy/done status and the word count back to software registers.

Parameters:
- ADDR_W, 10, port-A address width; buffer depth = 2^ADDR_W words.
- DATA_W, 64, port-A data width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- arm  in  1  software arm level; only the rising edge is used.
- use_sync  in  1  1 = capture starts at the first valid sample with sync_in high; 0 = starts at the first valid sample after arming.
- sync_in  in  1  PFB frame-start pulse, qualified by din_valid.
- din  in  DATA_W  PFB output word.
- din_valid  in  1  din qualifier.
- capture_len  in  ADDR_W+1  number of words to capture; 0 or > 2^ADDR_W means 2^ADDR_W.
- bram_we  out  1  port-A write enable.
- bram_en_a  out  1  port-A enable; equal to bram_we.
- bram_addr  out  ADDR_W  port-A word address.
- bram_wr_data  out  DATA_W  port-A write data.
- busy  out  1  high in WAIT_SYNC and CAPTURE.
- done  out  1  high in DONE.
- words_written  out  ADDR_W+1  words written by the current or last capture.

Behaviour:
- Reset values: all outputs 0; state IDLE; arm edge-detector history register = 1, so an arm held high through reset does not fire.
- Arm edge: arm_re = arm & ~arm_q, with arm_q registered every cycle.
- Length latch: on arm_re, eff_len = clamp(capture_len) is latched.
  - clamp(capture_len) is 2^ADDR_W when capture_len is 0 or exceeds 2^ADDR_W, otherwise capture_len.
  - capture_len changes after arm_re have no effect on the current capture.
- States:
  - IDLE: outputs idle. On arm_re: go to WAIT_SYNC if use_sync, else CAPTURE; clear words_written.
  - WAIT_SYNC: on din_valid & sync_in, that same sample is written at address 0 and the state becomes CAPTURE. Otherwise stay.
  - CAPTURE: each din_valid writes din at address words_written, then words_written increments. When the write makes words_written == eff_len, go to DONE.
  - DONE: done = 1 and words_written holds. On arm_re, re-arm exactly as from IDLE and clear done.
- use_sync: sampled only at arm_re.
- Write timing:
  - Port-A outputs are registered. A sample accepted in cycle N produces bram_we = 1 with its address and data in cycle N+1, so latency is 1 cycle.
  - bram_we is a single-cycle pulse per accepted word.
  - Gaps in din_valid stall the address with no write.
- Address: bram_addr = words_written[ADDR_W-1:0] at the time of acceptance. Addresses run 0 .. eff_len-1, and a full-depth capture never wraps.
- sync_in during CAPTURE is ignored, with no restart.
- Arm rising edge in WAIT_SYNC or CAPTURE is ignored; the capture continues.
- Status timing: busy falls and done rises in the cycle the last write is issued on port A, i.e. N+1 for a last sample accepted in cycle N.
- rst mid-capture: returns to IDLE next edge and clears every output; BRAM contents are untouched.
- After reset, arm must be seen low then high to start a capture.
- din_valid without arming: no writes.

Test Plan:
1. Basic capture:
   - Stimulus: reset; use_sync=0, capture_len=4; arm 0→1; din_valid continuous with din = 0x100+k.
   - Required: 4 writes at addr 0..3 with data 0x100..0x103, each 1 cycle after acceptance; done=1, busy=0, words_written=4; no 5th write.
2. Sync alignment:
   - Stimulus: use_sync=1, len=3; arm; valid samples 0xA0..0xA9 with sync_in on sample 0xA5.
   - Required: writes addr0=0xA5, addr1=0xA6, addr2=0xA7; nothing written before the sync.
3. Full depth and gapped valid:
   - Stimulus: capture_len=0, din_valid toggling 1,0,1,0.
   - Required: exactly 1024 writes at addr 0..1023 with no wrap; words_written=1024; bram_we never high in a cycle following a din_valid=0 cycle.
4. Re-arm and ignored arm:
   - Stimulus: arm pulse during CAPTURE.
   - Required: no restart and address continuity preserved.
   - Stimulus: new arm edge in DONE with len=2.
   - Required: done clears, words_written resets to 0, and 2 new writes at addr 0,1.
5. Reset mid-capture:
   - Stimulus: assert rst after 5 of 8 words, holding arm high.
   - Required: next cycle all outputs are 0 and the state is IDLE; no capture until arm goes low then high.
6. Length clamp:
   - Stimulus: capture_len=2000.
   - Required: treated as 1024; capture ends after 1024 writes.
